// File: rtl/abs_max_pkg.sv
// Shared widths and FSM encoding for the absolute-maximum vector scanner.
// No logic of its own; imported by abs_max_seq and absolute_value.
package abs_max_pkg;

   localparam int DATA_W_DEF = 9;
   localparam int LEN_W_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/absolute_value.sv
// Combinational two's-complement magnitude, returned unsigned at the same width.
// Zero latency, no flow control; the most negative input maps to 2^(DATA_W-1).
module absolute_value
   import abs_max_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] in_dat,
   output logic [DATA_W-1:0] abs_dat
);

   localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

   // Negating the most negative value yields its own bit pattern, which read unsigned is the magnitude.
   assign abs_dat = in_dat[DATA_W-1] ? (~in_dat + ONE) : in_dat;

endmodule

// File: rtl/abs_max_seq.sv
// Scans len signed samples and reports the largest magnitude and first index reaching it.
// Result valid 1 cycle after the last accepted beat; in_valid gaps stall, result holds until res_ready.
module abs_max_seq
   import abs_max_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_max,
   output logic [LEN_W-1:0]  res_idx
);

   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   max_q, max_d;
   logic [LEN_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   res_max_q, res_max_d;
   logic [LEN_W-1:0]    res_idx_q, res_idx_d;

   logic [DATA_W-1:0]   abs_dat;
   logic                beat;
   logic                upd;
   logic [DATA_W-1:0]   max_nxt;
   logic [LEN_W-1:0]    idx_nxt;
   logic                last_beat;

   absolute_value #(
      .DATA_W (DATA_W)
   ) u_abs (
      .in_dat  (in_data),
      .abs_dat (abs_dat)
   );

   assign beat      = in_valid && (state_q == SCAN);
   // Strict compare keeps the earliest index on ties.
   assign upd       = abs_dat > max_q;
   assign max_nxt   = upd ? abs_dat : max_q;
   assign idx_nxt   = upd ? cnt_q : idx_q;
   assign last_beat = (cnt_q == (len_q - LEN_ONE));

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      max_d     = max_q;
      idx_d     = idx_q;
      res_max_d = res_max_q;
      res_idx_d = res_idx_q;
      case (state_q)
         IDLE: begin
            if (start && (len != '0)) begin
               state_d = SCAN;
               len_d   = len;
               cnt_d   = '0;
               max_d   = '0;
               idx_d   = '0;
            end
         end
         SCAN: begin
            if (beat) begin
               max_d = max_nxt;
               idx_d = idx_nxt;
               cnt_d = cnt_q + LEN_ONE;
               // Result registers load only here, so they hold across the next scan.
               if (last_beat) begin
                  state_d   = DONE;
                  res_max_d = max_nxt;
                  res_idx_d = idx_nxt;
               end
            end
         end
         DONE: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         len_q     <= '0;
         cnt_q     <= '0;
         max_q     <= '0;
         idx_q     <= '0;
         res_max_q <= '0;
         res_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         max_q     <= max_d;
         idx_q     <= idx_d;
         res_max_q <= res_max_d;
         res_idx_q <= res_idx_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign in_ready  = (state_q == SCAN);
   assign res_valid = (state_q == DONE);
   assign res_max   = res_max_q;
   assign res_idx   = res_idx_q;

endmodule

// File: tb/tb_abs_max_seq.sv
// Table-driven and hand-sequenced checks of abs_max_seq against a result scoreboard.
module tb_abs_max_seq;

   localparam int DW = 9;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [LW-1:0] len;
   logic          busy;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_max;
   logic [LW-1:0] res_idx;

   abs_max_seq #(
      .DATA_W (DW),
      .LEN_W  (LW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_max   (res_max),
      .res_idx   (res_idx)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      int len;
      int off;
      int nst;
      int emax;
      int eidx;
   } vec_t;

   typedef struct {
      logic [DW-1:0] m;
      logic [LW-1:0] i;
   } exp_t;

   exp_t sb[$];
   int   smp[256];
   bit   stl[512];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Result monitor: every completed handshake must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         chk("result_expected", (sb.size() > 0), 1);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("res_max", res_max, e.m);
            chk("res_idx", res_idx, e.i);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic start_scan(input int L, input bit push, input int emax, input int eidx);
      exp_t e;
      start = 1'b1;
      len   = LW'(L);
      if (push) begin
         e.m = DW'(emax);
         e.i = LW'(eidx);
         sb.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b0;
      len   = LW'($urandom);
      if (L != 0) chk("busy_after_start", busy, 1);
   endtask

   task automatic feed(input int L, input int nst);
      int i, cyc, k, p;
      for (int j = 0; j < 512; j++) stl[j] = 1'b0;
      k = 0;
      while (k < nst) begin
         p = int'($urandom_range(L + nst - 2));
         if (!stl[p]) begin
            stl[p] = 1'b1;
            k++;
         end
      end
      i = 0;
      cyc = 0;
      while (i < L) begin
         chk("in_ready_scan", in_ready, 1);
         if (stl[cyc]) begin
            in_valid = 1'b0;
            in_data  = DW'(-256);
         end else begin
            in_valid = 1'b1;
            in_data  = DW'(smp[i]);
            i++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      in_data  = DW'($urandom);
   endtask

   task automatic run_scan(input int L, input int emax, input int eidx, input int nst);
      start_scan(L, 1'b1, emax, eidx);
      feed(L, nst);
      chk("res_valid_latency", res_valid, 1);
      @(posedge clk); #1;
      chk("idle_after_result", busy, 0);
   endtask

   vec_t tbl[8];
   int   pool[23] = '{15, -223, 0, -17, -93, -17, 17, -256, -17, 17, 1, 2, 3, 4, -5,
                      0, 0, 0, 7, -6, 5, 255, -256};

   initial begin
      tbl[0] = '{5, 0, 0, 223, 1};
      tbl[1] = '{3, 5, 0, 256, 2};
      tbl[2] = '{2, 8, 0, 17, 0};
      tbl[3] = '{4, 10, 2, 4, 3};
      tbl[4] = '{1, 14, 0, 5, 0};
      tbl[5] = '{3, 15, 0, 0, 0};
      tbl[6] = '{3, 18, 1, 7, 0};
      tbl[7] = '{2, 21, 0, 256, 1};

      rst       = 1'b1;
      start     = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_max", res_max, 0);
      chk("rst_res_idx", res_idx, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int v = 0; v < 8; v++) begin
         for (int s = 0; s < tbl[v].len; s++) smp[s] = pool[tbl[v].off + s];
         run_scan(tbl[v].len, tbl[v].emax, tbl[v].eidx, tbl[v].nst);
      end

      // Backpressure with a start attempted during DONE and during the handshake.
      smp[0] = 1; smp[1] = -9; smp[2] = 2;
      res_ready = 1'b0;
      start_scan(3, 1'b1, 9, 1);
      feed(3, 0);
      start = 1'b1;
      len   = 8'd2;
      for (int c = 0; c < 3; c++) begin
         chk("bp_res_valid", res_valid, 1);
         chk("bp_res_max", res_max, 9);
         chk("bp_res_idx", res_idx, 1);
         chk("bp_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      res_ready = 1'b1;
      chk("bp_res_valid_hs", res_valid, 1);
      @(posedge clk); #1;
      start = 1'b0;
      chk("bp_idle", busy, 0);
      chk("bp_res_valid_off", res_valid, 0);
      @(posedge clk); #1;
      chk("bp_start_ignored", busy, 0);
      chk("hold_res_max_idle", res_max, 9);
      chk("hold_res_idx_idle", res_idx, 1);

      // Result registers hold while a new scan runs.
      smp[0] = 1; smp[1] = 2;
      start_scan(2, 1'b1, 2, 1);
      chk("hold_res_max_scan", res_max, 9);
      feed(2, 0);
      chk("res_valid_latency2", res_valid, 1);
      @(posedge clk); #1;

      // Zero-length start is ignored.
      start_scan(0, 1'b0, 0, 0);
      for (int c = 0; c < 3; c++) begin
         chk("len0_busy", busy, 0);
         chk("len0_res_valid", res_valid, 0);
         @(posedge clk); #1;
      end

      // Reset after the second of five beats, with start and handshakes asserted.
      smp[0] = 100; smp[1] = -120;
      start_scan(5, 1'b0, 0, 0);
      feed(2, 0);
      rst      = 1'b1;
      start    = 1'b1;
      len      = 8'd3;
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", busy, 0);
      chk("abort_in_ready", in_ready, 0);
      chk("abort_res_valid", res_valid, 0);
      chk("abort_res_max", res_max, 0);
      chk("abort_res_idx", res_idx, 0);
      rst      = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("abort_stays_idle", busy, 0);
      smp[0] = -5;
      run_scan(1, 5, 0, 0);

      // Maximum length with a tie late in the vector; live len is scrambled during the scan.
      for (int s = 0; s < 255; s++) smp[s] = s % 100;
      smp[200] = -250;
      smp[230] = 250;
      run_scan(255, 250, 200, 0);

      chk("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/abs_max_seq.md
ABS_MAX_SEQ -- requirements
Module: abs_max_seq

Interface
REQ-001 The block SHALL have parameter DATA_W, default 9, meaning the width of signed input samples.
REQ-002 The block SHALL have parameter LEN_W, default 8, meaning the width of the vector-length field and of the index counter.
REQ-003 Port clk: input, 1 bit, the single clock; all logic SHALL be synchronous to clk's rising edge.
REQ-004 Port rst: input, 1 bit, reset; reset SHALL be synchronous and active-high.
REQ-005 Port start: input, 1 bit, a pulse that begins a scan.
REQ-006 Port len: input, LEN_W bits, the number of elements to scan; it is sampled on an accepted start.
REQ-007 Port busy: output, 1 bit; it SHALL be high whenever the state is not IDLE.
REQ-008 Port in_valid: input, 1 bit, marks a valid sample.
REQ-009 Port in_ready: output, 1 bit, the block accepts a sample.
REQ-010 Port in_data: input, DATA_W bits, a two's-complement sample.
REQ-011 Port res_valid: output, 1 bit, the result is available.
REQ-012 Port res_ready: input, 1 bit, the consumer accepts the result.
REQ-013 Port res_max: output, DATA_W bits, the unsigned maximum absolute value.
REQ-014 Port res_idx: output, LEN_W bits, the 0-based index of the first element that reached the maximum.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-016 In IDLE, a start with len != 0 SHALL, on the next edge, latch len, clear max, idx and cnt to 0, and enter SCAN.
REQ-017 In IDLE, a start with len == 0 SHALL be ignored, with no state change and no result.
REQ-018 A start received in SCAN or DONE SHALL be ignored.
REQ-019 in_ready SHALL equal (state == SCAN), decoded from the registered state only, with no combinational path from in_valid.
REQ-020 A beat SHALL be accepted only when in_valid && in_ready; no sample SHALL be consumed in any other cycle.
REQ-021 Per accepted beat, the block SHALL compute a = |in_data| with a DATA_W-bit unsigned result.
REQ-022 The value -2^(DATA_W-1) SHALL map to 2^(DATA_W-1), for example -256 maps to 256 at DATA_W=9; there is no saturation and no wrap.
REQ-023 Per accepted beat, if a > max, the block SHALL set max to a and idx to cnt.
REQ-024 Ties SHALL keep the earlier index, because the comparison is strictly greater.
REQ-025 Per accepted beat, cnt SHALL increment by 1.
REQ-026 When the beat with cnt == len-1 is accepted, the next state SHALL be DONE, and the updated max and idx SHALL be visible in that DONE cycle.
REQ-027 Latency SHALL be 1 cycle from the final accepted beat to res_valid high.
REQ-028 Gaps where in_valid is low during SCAN SHALL stall the scan without affecting any state.
REQ-029 In DONE, res_valid SHALL be 1.
REQ-030 In DONE, res_max and res_idx SHALL be held stable until res_valid && res_ready.
REQ-031 When res_valid && res_ready, the next state SHALL be IDLE.
REQ-032 res_valid may stall indefinitely while res_ready stays low.
REQ-033 Outside DONE, res_valid SHALL be 0, and res_max and res_idx SHALL hold their last values.
REQ-034 A start arriving in the same cycle as the result handshake SHALL be ignored; a new start is accepted only from IDLE on a later cycle.
REQ-035 If len equals 2^LEN_W - 1, cnt SHALL NOT wrap before termination.
REQ-036 The termination compare SHALL use the latched len, not the live len input.

Reset
REQ-037 On rst high at a clock edge, the block SHALL enter IDLE regardless of state, aborting any scan in progress or pending result.
REQ-038 During reset, busy, in_ready and res_valid SHALL be 0.
REQ-039 During reset, res_max, res_idx, max, idx, cnt and the latched len SHALL be cleared to 0.
REQ-040 rst SHALL take priority over start and over all handshakes in the same cycle.
REQ-041 After reset, no partial result from an aborted scan SHALL ever be presented.

Structure
REQ-042 Package abs_max_pkg SHALL hold the DATA_W and LEN_W defaults and the state enum {IDLE, SCAN, DONE}.
REQ-043 The absolute-value operation SHALL be the existing combinational absolute_value block, instantiated once as the only sub-module.
REQ-044 Everything else (FSM, counter, comparator and result registers) SHALL be in abs_max_seq.

Verification
REQ-045 Basic scan: len=5, samples 15, -223, 0, -17, -93 with in_valid held high -> res_valid one cycle after the 5th beat, with res_max=223 and res_idx=1.
REQ-046 Tie and minimum value: len=3, samples -17, 17, -256 -> res_max=256 and res_idx=2; separately, len=2, samples -17, 17 -> res_max=17 and res_idx=0.
REQ-047 Stalls: len=4 with in_valid low on 2 random cycles, samples 1, 2, 3, 4 -> res_max=4 and res_idx=3, with no extra or lost beats.
REQ-048 Backpressure: res_ready held low 3 cycles in DONE -> res_valid and outputs stable throughout, IDLE the cycle after res_ready rises, and a start during DONE ignored.
REQ-049 len=0: start with len=0 -> busy stays 0 and no res_valid is seen.
REQ-050 Reset mid-operation: rst asserted after the 2nd of 5 beats -> next cycle busy=0 and in_ready=0 with all outputs 0; a fresh len=1 scan of -5 then yields res_max=5 and res_idx=0.
